spi_word_engine: RTL and testbench
==================================

Name: spi_word_engine

Overview:
- Word-level transaction controller sitting directly upstream of the SPI clock/chip-select former.
- Accepts a parallel TX word via a valid/ready handshake and drives `work` to the former.
- Tracks the former's `cs`: serializes the word MSB-first onto `mosi`, deserializes `miso` into an RX word, and returns the result with a one-cycle `rx_valid` pulse.
- Flags chip-select timeout and mid-word abort.

Parameters:
- WIDTH, 16, bits per transaction; matches the former's 4-bit `cnt` range.
- CS_TIMEOUT, 8, clk cycles allowed between `work` rising and `cs` falling before error.
- GAP_CYCLES, 2, minimum idle clk cycles with `work` low between consecutive words.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous reset, active-low.
- tx_data  in  WIDTH  word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  engine accepts tx_data this cycle.
- rx_data  out  WIDTH  last received word; held until next completion.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- err_timeout  out  1  one-cycle pulse: cs never fell within CS_TIMEOUT.
- err_abort  out  1  one-cycle pulse: cs rose before WIDTH bits were sampled.
- work  out  1  transaction request to the clk/cs former.
- cs  in  1  chip select from the former, active-low.
- miso  in  1  serial data from the slave.
- mosi  out  1  serial data to the slave.

Behaviour:
- Reset (rst_n low at posedge):
  - state=IDLE; work=0, tx_ready=0, rx_valid=0, err_timeout=0, err_abort=0.
  - rx_data=0, mosi=0, bit_cnt=0, tx_shift=0, rx_shift=0, timer=0.
  - Reset mid-transaction drops `work` on the next edge; no rx_valid or error pulse is generated.
- IDLE:
  - tx_ready=1 when gap timer ≥ GAP_CYCLES.
  - On tx_valid&&tx_ready: tx_shift<=tx_data, bit_cnt<=0, timer<=0, work<=1, tx_ready<=0, go START.
  - tx_valid while tx_ready=0 is held off; data is not sampled.
- START:
  - timer increments each cycle.
  - cs==0 → go SHIFT (same edge).
  - Else if timer==CS_TIMEOUT-1 → work<=0, err_timeout pulse, go STOP.
- SHIFT, each posedge with cs==0:
  - rx_shift<={rx_shift[WIDTH-2:0],miso}; tx_shift<=tx_shift<<1; bit_cnt++.
  - When bit_cnt==WIDTH-1 on that edge: word complete, work<=0, go STOP.
- SHIFT, cs==1 before completion: work<=0, err_abort pulse, go STOP; rx_data unchanged.
- mosi = tx_shift[WIDTH-1] (registered path). The first bit is valid from START entry, before cs falls.
- STOP:
  - Wait for cs==1, then go DONE.
  - On a successful word, rx_data<=rx_shift (including final bit) and rx_valid pulses in the DONE cycle.
- DONE: one cycle; gap timer cleared; go IDLE.
- Error paths reach IDLE with no rx_valid.
- Error pulses and rx_valid are mutually exclusive.
- Back-to-back: next word accepted no earlier than GAP_CYCLES+1 cycles after DONE.

Decomposition:
- Shared package spi_pkg:
  - SPI_WIDTH=16.
  - State encoding: IDLE=0, START=1, SHIFT=2, STOP=3, DONE=4 (3-bit).
  - Default CS_TIMEOUT.
- Natural sub-module: spi_shift_pair (WIDTH-bit TX/RX shift registers with load/shift enables).
- FSM and timers stay in spi_word_engine.

Test Plan:
- Basic word: tx_data=16'hA5C3, former model drops cs 2 cycles after work, miso loops back mosi → mosi sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; rx_valid single pulse; rx_data=16'hA5C3.
- Fixed miso=1, tx=16'h0000 → rx_data=16'hFFFF; mosi constant 0.
- Timeout: cs held high after work → err_timeout pulse exactly CS_TIMEOUT cycles after acceptance; work falls; no rx_valid; tx_ready returns after gap.
- Abort: cs rises after 7 bits → err_abort pulse; rx_data retains previous value; engine returns to IDLE.
- Back-to-back: tx_valid held high with words 16'h1234, 16'hFEDC → two rx_valid pulses; tx_ready low for ≥GAP_CYCLES between; rx_data matches each word under loopback.
- Reset mid-SHIFT at bit 9 → next edge: work=0, all outputs at reset values; next transaction completes normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI word engine: default geometry, timing limits
// and the controller state encoding.
package spi_pkg;

    localparam int SPI_WIDTH      = 16;
    localparam int SPI_CS_TIMEOUT = 8;
    localparam int SPI_GAP_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        SHIFT = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_word_if.sv
// Host-side word handshake of the SPI word engine: TX valid/ready in,
// RX word with completion/error pulses out.
interface spi_word_if import spi_pkg::*; #(
    parameter int WIDTH = SPI_WIDTH
) ();

    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             err_timeout;
    logic             err_abort;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, err_timeout, err_abort
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, err_timeout, err_abort
    );

endinterface

// File: rtl/spi_shift_pair.sv
// Paired TX/RX shift registers: TX loads in parallel and shifts out MSB-first,
// RX shifts serial input in at the LSB on the same enable.
module spi_shift_pair import spi_pkg::*; #(
    parameter int WIDTH = SPI_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    input  logic             sin,
    output logic             sout,
    output logic [WIDTH-1:0] rx_word
);

    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] rx_shift;

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would make results depend on statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_shift <= '0;
            rx_shift <= '0;
        end else begin
            if (load)
                tx_shift <= load_data;
            else if (shift)
                tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
            if (shift)
                rx_shift <= {rx_shift[WIDTH-2:0], sin};
        end
    end

    assign sout    = tx_shift[WIDTH-1];
    assign rx_word = rx_shift;

endmodule

// File: rtl/spi_word_engine.sv
// Word-level SPI transaction controller: requests a transfer from the clk/cs
// former, shifts one word each way while cs is low, and reports the outcome.
module spi_word_engine import spi_pkg::*; #(
    parameter int WIDTH      = SPI_WIDTH,
    parameter int CS_TIMEOUT = SPI_CS_TIMEOUT,
    parameter int GAP_CYCLES = SPI_GAP_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    spi_word_if.slave  host,
    output logic       work,
    input  logic       cs,
    input  logic       miso,
    output logic       mosi
);

    localparam int TW = $clog2(max2(CS_TIMEOUT, GAP_CYCLES) + 1);
    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [TW-1:0]    timer;
    logic [CW-1:0]    bit_cnt;
    logic             word_ok;
    logic             accept;
    logic             shift_en;
    logic [WIDTH-1:0] rx_word;

    assign accept   = (state == IDLE) && host.tx_valid && host.tx_ready;
    assign shift_en = (state == SHIFT) && !cs;

    spi_shift_pair #(.WIDTH(WIDTH)) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .shift     (shift_en),
        .load_data (host.tx_data),
        .sin       (miso),
        .sout      (mosi),
        .rx_word   (rx_word)
    );

    // One timer serves as the idle-gap counter in IDLE and the cs watchdog in START.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            timer            <= '0;
            bit_cnt          <= '0;
            word_ok          <= 1'b0;
            work             <= 1'b0;
            host.tx_ready    <= 1'b0;
            host.rx_valid    <= 1'b0;
            host.err_timeout <= 1'b0;
            host.err_abort   <= 1'b0;
            host.rx_data     <= '0;
        end else begin
            host.rx_valid    <= 1'b0;
            host.err_timeout <= 1'b0;
            host.err_abort   <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        bit_cnt       <= '0;
                        timer         <= '0;
                        word_ok       <= 1'b0;
                        work          <= 1'b1;
                        host.tx_ready <= 1'b0;
                        state         <= START;
                    end else begin
                        if (int'(timer) < GAP_CYCLES)
                            timer <= timer + 1'b1;
                        host.tx_ready <= (int'(timer) + 1 >= GAP_CYCLES);
                    end
                end

                START: begin
                    timer <= timer + 1'b1;
                    if (!cs) begin
                        state <= SHIFT;
                    end else if (timer == TW'(CS_TIMEOUT - 1)) begin
                        work             <= 1'b0;
                        host.err_timeout <= 1'b1;
                        state            <= STOP;
                    end
                end

                SHIFT: begin
                    if (!cs) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == CW'(WIDTH - 1)) begin
                            work    <= 1'b0;
                            word_ok <= 1'b1;
                            state   <= STOP;
                        end
                    end else begin
                        work           <= 1'b0;
                        host.err_abort <= 1'b1;
                        state          <= STOP;
                    end
                end

                // rx_word already holds the final bit shifted in on the last SHIFT edge.
                STOP: begin
                    if (cs) begin
                        state <= DONE;
                        if (word_ok) begin
                            host.rx_data  <= rx_word;
                            host.rx_valid <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    timer <= '0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_word_engine.sv
// Self-checking bench for spi_word_engine with a behavioural clk/cs former,
// directed vector table, randomized words and multi-cycle corner sequences.
module tb_spi_word_engine;
    import spi_pkg::*;

    localparam int W   = SPI_WIDTH;
    localparam int TO  = SPI_CS_TIMEOUT;
    localparam int GAP = SPI_GAP_CYCLES;

    typedef enum int {K_OK, K_TO, K_AB} kind_t;

    typedef struct {
        logic [W-1:0] tx;
        bit           loop;
        logic [W-1:0] mword;
        int           dly;
        int           abits;
        kind_t        kind;
        logic [W-1:0] exp_rx;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic work;
    logic cs    = 1'b1;
    logic miso  = 1'b0;
    logic mosi;

    spi_word_if #(.WIDTH(W)) bus ();

    spi_word_engine #(.WIDTH(W), .CS_TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .host  (bus),
        .work  (work),
        .cs    (cs),
        .miso  (miso),
        .mosi  (mosi)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    int cyc = 0, acc_cyc = -1, to_cyc = -1;
    bit accepted = 0;
    int f_dly = 2, f_abits = W;
    bit f_loop = 1;
    logic [W-1:0] f_mword = '0;
    int wk_cnt = 0, lo_cnt = 0;
    logic [W-1:0] mosi_bits = '0;
    int nbits = 0;
    int n_rxv = 0, n_to = 0, n_ab = 0;
    bit err_work_hi = 0;
    logic [W-1:0] exp_hold = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock: observe the edge, then update the former model and drive inputs.
    task automatic tick();
        logic p_cs, p_mosi, p_acc;
        p_cs   = cs;
        p_mosi = mosi;
        p_acc  = bus.tx_valid && bus.tx_ready && rst_n;
        @(posedge clk);
        #1;
        cyc++;
        if (p_acc) begin
            accepted = 1;
            acc_cyc  = cyc;
        end
        if (!p_cs) begin
            lo_cnt++;
            if (lo_cnt > 1 && nbits < W) begin
                mosi_bits = {mosi_bits[W-2:0], p_mosi};
                nbits++;
            end
        end
        if (bus.rx_valid) n_rxv++;
        if (bus.err_timeout) begin
            n_to++;
            to_cyc = cyc;
            if (work) err_work_hi = 1;
        end
        if (bus.err_abort) begin
            n_ab++;
            if (work) err_work_hi = 1;
        end
        if (work) wk_cnt++;
        else begin
            wk_cnt = 0;
            lo_cnt = 0;
        end
        if (!work)
            cs = 1'b1;
        else if (!cs && f_abits < W && lo_cnt == f_abits + 1)
            cs = 1'b1;
        else if (cs && lo_cnt == 0 && wk_cnt >= f_dly)
            cs = 1'b0;
        miso = f_loop ? mosi : ((nbits < W) ? f_mword[W-1-nbits] : 1'b0);
    endtask

    task automatic clear_obs();
        nbits = 0; mosi_bits = '0; n_rxv = 0; n_to = 0; n_ab = 0;
        accepted = 0; err_work_hi = 0; to_cyc = -1; acc_cyc = -1;
    endtask

    function automatic vec_t model(input logic [W-1:0] tx, input bit loop, input logic [W-1:0] mword,
                                   input int dly, input int abits, input logic [W-1:0] held);
        vec_t v;
        v.tx = tx; v.loop = loop; v.mword = mword; v.dly = dly; v.abits = abits;
        if (dly > TO)       v.kind = K_TO;
        else if (abits < W) v.kind = K_AB;
        else                v.kind = K_OK;
        v.exp_rx = (v.kind == K_OK) ? (loop ? tx : mword) : held;
        return v;
    endfunction

    task automatic run_word(input vec_t v, input string tag);
        int guard;
        bit done_ev;
        logic [23:0] exp_p;
        f_dly = v.dly; f_abits = v.abits; f_loop = v.loop; f_mword = v.mword;
        clear_obs();
        bus.tx_data  = v.tx;
        bus.tx_valid = 1'b1;
        guard = 0;
        done_ev = 0;
        while (guard < 200 && !(done_ev && bus.tx_ready)) begin
            tick();
            guard++;
            if (accepted) bus.tx_valid = 1'b0;
            if (n_rxv + n_to + n_ab > 0) done_ev = 1;
        end
        bus.tx_valid = 1'b0;
        if (guard >= 200) check({tag, "_bound"}, 64'd0, 64'd1);
        exp_p = (v.kind == K_OK) ? 24'h010000 : (v.kind == K_TO) ? 24'h000100 : 24'h000001;
        check({tag, "_pulses"}, {8'(n_rxv), 8'(n_to), 8'(n_ab)}, exp_p);
        exp_hold = v.exp_rx;
        check({tag, "_rx_data"}, bus.rx_data, exp_hold);
        check({tag, "_work_at_err"}, err_work_hi, 0);
        if (v.kind == K_OK) check({tag, "_mosi"}, mosi_bits, v.tx);
        if (v.kind == K_TO) check({tag, "_to_latency"}, to_cyc - acc_cyc, TO);
    endtask

    vec_t tbl[7];
    logic [W-1:0] rx_q[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{16'hA5C3, 1'b1, 16'h0000, 2,      W, K_OK, 16'hA5C3};
        tbl[1] = '{16'h0000, 1'b0, 16'hFFFF, 2,      W, K_OK, 16'hFFFF};
        tbl[2] = '{16'h3C3C, 1'b1, 16'h0000, TO + 1, W, K_TO, 16'hFFFF};
        tbl[3] = '{16'h5A5A, 1'b1, 16'h0000, 2,      7, K_AB, 16'hFFFF};
        tbl[4] = '{16'h8001, 1'b1, 16'h0000, TO,     W, K_OK, 16'h8001};
        tbl[5] = '{16'h7FFE, 1'b0, 16'h0000, 1,      W, K_OK, 16'h0000};
        tbl[6] = '{16'hC001, 1'b1, 16'h0000, 2,      0, K_AB, 16'h0000};

        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_outs",
              {work, bus.tx_ready, bus.rx_valid, bus.err_timeout, bus.err_abort, mosi, bus.rx_data},
              '0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_word(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back with tx_valid held high through the gap.
        f_loop = 1; f_dly = 2; f_abits = W;
        clear_obs();
        rx_q.delete();
        begin
            int acc_n, done_at, guard;
            int acc_at[2];
            acc_n = 0; done_at = -1; guard = 0;
            acc_at[0] = -1; acc_at[1] = -1;
            bus.tx_data  = 16'h1234;
            bus.tx_valid = 1'b1;
            while (guard < 300 && n_rxv < 2) begin
                tick();
                guard++;
                if (accepted) begin
                    accepted = 0;
                    if (acc_n < 2) acc_at[acc_n] = acc_cyc;
                    acc_n++;
                    nbits = 0;
                    bus.tx_data = 16'hFEDC;
                    if (acc_n >= 2) bus.tx_valid = 1'b0;
                end
                if (bus.rx_valid) begin
                    rx_q.push_back(bus.rx_data);
                    if (done_at < 0) done_at = cyc;
                end
            end
            bus.tx_valid = 1'b0;
            check("b2b_rx_count", n_rxv, 2);
            check("b2b_errs", n_to + n_ab, 0);
            check("b2b_word0", (rx_q.size() > 0) ? rx_q[0] : 16'hxxxx, 16'h1234);
            check("b2b_word1", (rx_q.size() > 1) ? rx_q[1] : 16'hxxxx, 16'hFEDC);
            check("b2b_gap_ok", (done_at >= 0 && acc_at[1] - done_at >= GAP + 1), 1);
            exp_hold = 16'hFEDC;
            guard = 0;
            while (guard < 50 && !bus.tx_ready) begin
                tick();
                guard++;
            end
            check("b2b_ready_back", bus.tx_ready, 1);
        end

        for (int i = 0; i < 30; i++) begin
            vec_t v;
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : W;
            v = model(W'($urandom), 1'($urandom_range(0, 1)), W'($urandom),
                      int'($urandom_range(1, TO + 2)), ab, exp_hold);
            run_word(v, $sformatf("rnd%0d", i));
        end

        // Reset while the ninth bit has just been shifted.
        f_loop = 1; f_dly = 2; f_abits = W;
        clear_obs();
        bus.tx_data  = 16'h9C6B;
        bus.tx_valid = 1'b1;
        begin
            int guard;
            guard = 0;
            while (guard < 100 && nbits < 9) begin
                tick();
                guard++;
                if (accepted) bus.tx_valid = 1'b0;
            end
            check("rst_mid_reached_bit9", nbits, 9);
        end
        n_rxv = 0; n_to = 0; n_ab = 0;
        rst_n = 1'b0;
        tick();
        check("rst_mid_outs",
              {work, bus.tx_ready, bus.rx_valid, bus.err_timeout, bus.err_abort, mosi, bus.rx_data},
              '0);
        tick();
        rst_n = 1'b1;
        check("rst_mid_no_pulse", n_rxv + n_to + n_ab, 0);
        exp_hold = '0;
        run_word(model(16'h4B1D, 1'b1, 16'h0000, 2, W, exp_hold), "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
